// File: rtl/lbp_stream_engine.sv
// Streams a raster frame once, builds a 3x3 window from two line buffers and
// writes an 8-bit LBP code (border = 0) for every address in ascending order.
module lbp_stream_engine #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    input  logic [DW-1:0] thr,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
    localparam logic [AW-1:0] CTR_OFF    = AW'(IMG_W + 1);
    localparam logic [AW-1:0] FLUSH_BASE = AW'(N - IMG_W - 1);
    localparam logic [AW-1:0] FLUSH_END  = AW'(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          capture;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] fcnt;
    logic [DW-1:0] thr_q;

    logic [DW-1:0] lb_a [IMG_W];
    logic [DW-1:0] lb_b [IMG_W];
    logic [DW-1:0] wl [3];
    logic [DW-1:0] wc [3];
    logic [DW-1:0] nb [8];
    logic [DW:0]   ref_lvl;
    logic [7:0]    code;
    logic          border;

    always_comb begin
        state_nxt = state;
        gray_req  = 1'b0;
        case (state)
            IDLE:  if (gray_ready) state_nxt = FETCH;
            FETCH: begin
                gray_req = gray_ready;
                if (gray_ready && gray_addr == LAST_ADDR) state_nxt = FLUSH;
            end
            FLUSH: if (fcnt == FLUSH_END) state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign capture = gray_req;

    // Window after the incoming column shifts in; centre is pixel k-IMG_W-1.
    always_comb begin
        nb[0]   = wl[0];
        nb[1]   = wc[0];
        nb[2]   = lb_b[col];
        nb[3]   = wl[1];
        nb[4]   = lb_a[col];
        nb[5]   = wl[2];
        nb[6]   = wc[2];
        nb[7]   = gray_data;
        ref_lvl = {1'b0, wc[1]} + {1'b0, thr_q};
        code    = 8'h00;
        for (int i = 0; i < 8; i++) begin
            code[i] = ({1'b0, nb[i]} >= ref_lvl);
        end
    end

    // Incoming col 0/1 means the centre sits on the right/left edge; row 1 means top row.
    assign border = (col == CW'(0)) || (col == CW'(1)) || (row == RW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gray_addr <= '0;
            col       <= '0;
            row       <= '0;
            fcnt      <= '0;
            thr_q     <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= 8'h00;
            finish    <= 1'b0;
        end else begin
            state     <= state_nxt;
            finish    <= (state_nxt == DONE);
            lbp_valid <= 1'b0;
            if (state == IDLE && gray_ready) thr_q <= thr;
            if (capture) begin
                if (gray_addr != LAST_ADDR) gray_addr <= gray_addr + AW'(1);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (gray_addr >= CTR_OFF) begin
                    lbp_valid <= 1'b1;
                    lbp_addr  <= gray_addr - CTR_OFF;
                    lbp_data  <= border ? 8'h00 : code;
                end
            end
            if (state == FLUSH) begin
                fcnt <= fcnt + AW'(1);
                if (fcnt < FLUSH_END) begin
                    lbp_valid <= 1'b1;
                    lbp_addr  <= FLUSH_BASE + fcnt;
                    lbp_data  <= 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            lb_a[col] <= gray_data;
            lb_b[col] <= lb_a[col];
            wl        <= wc;
            wc[0]     <= lb_b[col];
            wc[1]     <= lb_a[col];
            wc[2]     <= gray_data;
        end
    end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Random frames, thresholds and stalls on a 6x5 engine, checked against an
// address-level LBP model of the frame held in the bench.
module tb_lbp_stream_engine;

    localparam int W  = 6;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gray_ready = 1'b0;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [7:0]    gray_data;
    logic [7:0]    thr = 8'h00;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    logic [7:0] pix [N];
    int errors = 0;
    int checks = 0;

    lbp_stream_engine #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
        .gray_addr(gray_addr), .gray_data(gray_data), .thr(thr),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish)
    );

    assign gray_data = pix[gray_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_code(input int a, input int t);
        int r = a / W;
        int c = a % W;
        int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int res = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int i = 0; i < 8; i++) begin
            if (int'(pix[(r + dr[i]) * W + c + dc[i]]) >= int'(pix[a]) + t) res |= (1 << i);
        end
        return res;
    endfunction

    task automatic fill(input int mode, input int val);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: pix[i] = 8'($urandom_range(255));
                1: pix[i] = 8'($urandom_range(7));
                2: pix[i] = 8'(val);
                default: pix[i] = $urandom_range(1) ? 8'd255 : 8'd0;
            endcase
        end
    endtask

    task automatic reset_check();
        @(negedge clk);
        reset = 1'b1;
        gray_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_gray_req", gray_req, 0);
        chk("rst_gray_addr", gray_addr, 0);
        chk("rst_lbp_valid", lbp_valid, 0);
        chk("rst_lbp_addr", lbp_addr, 0);
        chk("rst_lbp_data", lbp_data, 0);
        chk("rst_finish", finish, 0);
        gray_ready = 1'b0;
    endtask

    task automatic run_frame(input int t, input int stall_pct, input int abort_at);
        int  exp_addr = 0;
        int  nwr = 0;
        int  cyc = 0;
        int  start_cyc = -1;
        bit  started = 0;
        thr = 8'(t);
        while (!finish && cyc < 20 * N + 200) begin
            if (abort_at >= 0 && exp_addr >= abort_at) begin
                reset_check();
                return;
            end
            @(negedge clk);
            cyc++;
            if (lbp_valid) begin
                chk("wr_addr", int'(lbp_addr), nwr);
                if (nwr < N) chk("wr_data", int'(lbp_data), model_code(nwr, t));
                nwr++;
            end
            if (started) thr = 8'($urandom_range(255));
            gray_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (!gray_ready) chk("req_in_stall", gray_req, 0);
            if (!gray_ready && exp_addr < N) chk("addr_hold", int'(gray_addr), exp_addr);
            if (gray_req) begin
                chk("gray_addr", int'(gray_addr), exp_addr);
                exp_addr++;
            end
            if (gray_ready && !started) begin
                started = 1;
                start_cyc = cyc;
            end
        end
        chk("finish_set", finish, 1);
        chk("n_writes", nwr, N);
        chk("n_reads", exp_addr, N);
        if (stall_pct == 0)
            chk("frame_cycles", int'(cyc - start_cyc >= N + W + 2 && cyc - start_cyc <= N + W + 4), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            gray_ready = $urandom_range(1) != 0;
            #1;
            chk("done_valid", lbp_valid, 0);
            chk("done_req", gray_req, 0);
            chk("finish_hold", finish, 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_check();

        fill(0, 0);   run_frame(0, 0, -1);                       reset_check();
        fill(0, 0);   run_frame($urandom_range(40), 30, -1);     reset_check();
        for (int f = 0; f < 3; f++) begin
            fill(1, 0); run_frame($urandom_range(3), 30, -1);    reset_check();
        end
        fill(2, 100); run_frame(0, 0, -1);                       reset_check();
        fill(2, 100); run_frame(1, 30, -1);                      reset_check();
        fill(2, 100); run_frame(200, 0, -1);                     reset_check();
        fill(3, 0);   run_frame(0, 30, -1);                      reset_check();
        fill(3, 0);   run_frame(255, 0, -1);                     reset_check();
        fill(0, 0);   run_frame(5, 0, N / 2);
        fill(0, 0);   run_frame(5, 0, -1);                       reset_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
